// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit interface engine: power-on init, then byte writes split into two
// nibbles with setup/strobe/hold timing and per-command post waits.
module lcd_nibble_writer #(
  parameter int SETUP_CYC      = 2,
  parameter int E_HIGH_CYC     = 12,
  parameter int HOLD_CYC       = 1,
  parameter int GAP_CYC        = 50,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int PWR_WAIT_CYC   = 750000,
  parameter int INIT1_WAIT_CYC = 205000,
  parameter int INIT2_WAIT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_d
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int NIB_CYC = SETUP_CYC + E_HIGH_CYC + HOLD_CYC;
  localparam int MAX_CYC = max_of(max_of(max_of(NIB_CYC, GAP_CYC),
                                         max_of(CMD_WAIT_CYC, CLEAR_WAIT_CYC)),
                                  max_of(PWR_WAIT_CYC,
                                         max_of(INIT1_WAIT_CYC, INIT2_WAIT_CYC)));
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // Counters load duration-1 on state entry and leave the state at zero.
  localparam cnt_t NIB_LD   = cnt_t'(NIB_CYC - 1);
  localparam cnt_t GAP_LD   = cnt_t'(GAP_CYC - 1);
  localparam cnt_t CMD_LD   = cnt_t'(CMD_WAIT_CYC - 1);
  localparam cnt_t CLEAR_LD = cnt_t'(CLEAR_WAIT_CYC - 1);
  localparam cnt_t PWR_LD   = cnt_t'(PWR_WAIT_CYC - 1);
  localparam cnt_t INIT1_LD = cnt_t'(INIT1_WAIT_CYC - 1);
  localparam cnt_t INIT2_LD = cnt_t'(INIT2_WAIT_CYC - 1);
  localparam cnt_t E_LO_C   = cnt_t'(HOLD_CYC);
  localparam cnt_t E_HI_C   = cnt_t'(E_HIGH_CYC + HOLD_CYC - 1);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_NIB, INIT_WAIT, IDLE, SEND_HI, GAP, SEND_LO, POST_WAIT
  } state_t;

  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  function automatic cnt_t init_wait(input logic [1:0] idx);
    case (idx)
      2'd0:    return INIT1_LD;
      2'd1:    return INIT2_LD;
      default: return CMD_LD;
    endcase
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  // Clear and home need the long execution time; everything else the short one.
  function automatic cnt_t post_wait(input logic rs, input logic [7:0] d);
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03))
      return CLEAR_LD;
    return CMD_LD;
  endfunction

  state_t     state, state_nxt;
  cnt_t       cnt, cnt_nxt;
  logic [1:0] step, step_nxt;
  logic [7:0] byte_q, byte_nxt;
  logic [3:0] d_nxt;
  logic       rs_nxt;
  logic       done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWR_WAIT;
      cnt       <= PWR_LD;
      step      <= 2'd0;
      init_done <= 1'b0;
      lcd_d     <= 4'h0;
      lcd_rs    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      step      <= step_nxt;
      init_done <= done_nxt;
      lcd_d     <= d_nxt;
      lcd_rs    <= rs_nxt;
    end
  end

  always_ff @(posedge clk) begin
    byte_q <= byte_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step_nxt  = step;
    byte_nxt  = byte_q;
    d_nxt     = lcd_d;
    rs_nxt    = lcd_rs;
    done_nxt  = init_done;
    case (state)
      PWR_WAIT: begin
        if (cnt == '0) begin
          state_nxt = INIT_NIB;
          cnt_nxt   = NIB_LD;
          d_nxt     = init_nibble(step);
          rs_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      INIT_NIB: begin
        if (cnt == '0) begin
          state_nxt = INIT_WAIT;
          cnt_nxt   = init_wait(step);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      INIT_WAIT: begin
        if (cnt == '0) begin
          cnt_nxt = NIB_LD;
          if (step == 2'd3) begin
            // Nibble phase over; step now indexes the init command bytes.
            step_nxt  = 2'd0;
            byte_nxt  = init_byte(2'd0);
            d_nxt     = byte_nxt[7:4];
            state_nxt = SEND_HI;
          end else begin
            step_nxt  = step + 2'd1;
            d_nxt     = init_nibble(step + 2'd1);
            state_nxt = INIT_NIB;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      IDLE: begin
        if (wr_valid) begin
          byte_nxt  = wr_data;
          rs_nxt    = wr_rs;
          d_nxt     = wr_data[7:4];
          cnt_nxt   = NIB_LD;
          state_nxt = SEND_HI;
        end
      end
      SEND_HI: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = SEND_LO;
          cnt_nxt   = NIB_LD;
          d_nxt     = byte_q[3:0];
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      SEND_LO: begin
        if (cnt == '0) begin
          state_nxt = POST_WAIT;
          cnt_nxt   = post_wait(lcd_rs, byte_q);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      POST_WAIT: begin
        if (cnt == '0) begin
          if (init_done) begin
            state_nxt = IDLE;
          end else if (step == 2'd3) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            step_nxt  = step + 2'd1;
            byte_nxt  = init_byte(step + 2'd1);
            rs_nxt    = 1'b0;
            d_nxt     = byte_nxt[7:4];
            cnt_nxt   = NIB_LD;
            state_nxt = SEND_HI;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = PWR_WAIT;
        cnt_nxt   = PWR_LD;
      end
    endcase
  end

  // Strobe window inside a nibble: counts NIB-1..0, high between hold and setup margins.
  assign lcd_e    = ((state == INIT_NIB) || (state == SEND_HI) || (state == SEND_LO))
                    && (cnt >= E_LO_C) && (cnt <= E_HI_C);
  assign wr_ready = (state == IDLE);
  assign lcd_rw   = 1'b0;

endmodule
